// File: rtl/gray_counter_if.sv
// Bundle for the Gray counter: counter controls/status plus the converter stream.
// The master side drives the controls and operands; the slave side (the counter) drives the results.
interface gray_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;
    logic             cvt_valid_in;
    logic             cvt_mode;
    logic [WIDTH-1:0] cvt_data_in;
    logic             cvt_valid_out;
    logic [WIDTH-1:0] cvt_data_out;

    modport master (
        output en, up, load, load_bin, cvt_valid_in, cvt_mode, cvt_data_in,
        input  bin, gray, tc, cvt_valid_out, cvt_data_out
    );

    modport slave (
        input  en, up, load, load_bin, cvt_valid_in, cvt_mode, cvt_data_in,
        output bin, gray, tc, cvt_valid_out, cvt_data_out
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with parallel load and wrap flag, plus an
// independent 1-cycle pipelined binary<->Gray converter.
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    gray_counter_if.slave bus
);
    localparam int unsigned W = WIDTH;

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down: b[i] = ^g[W-1:i].
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int unsigned k = 1; k < W; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

    logic [W-1:0] bin_q;
    logic [W-1:0] bin_d;
    logic [W-1:0] gray_q;
    logic         tc_q;
    logic         tc_d;
    logic         cvt_valid_q;
    logic [W-1:0] cvt_data_q;
    logic [W-1:0] cvt_data_d;

    // Next count: load beats enable; wrap is flagged on the step itself.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                bin_d = bin_q + W'(1);
                tc_d  = (bin_q == {W{1'b1}});
            end else begin
                bin_d = bin_q - W'(1);
                tc_d  = (bin_q == {W{1'b0}});
            end
        end
    end

    always_comb begin
        cvt_data_d = cvt_data_q;
        if (bus.cvt_valid_in) begin
            cvt_data_d = bus.cvt_mode ? gray2bin(bus.cvt_data_in) : bin2gray(bus.cvt_data_in);
        end
    end

    // Gray is registered from the next binary value so both update on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q       <= '0;
            gray_q      <= '0;
            tc_q        <= 1'b0;
            cvt_valid_q <= 1'b0;
            cvt_data_q  <= '0;
        end else begin
            bin_q       <= bin_d;
            gray_q      <= bin2gray(bin_d);
            tc_q        <= tc_d;
            cvt_valid_q <= bus.cvt_valid_in;
            cvt_data_q  <= cvt_data_d;
        end
    end

    assign bus.bin           = bin_q;
    assign bus.gray          = gray_q;
    assign bus.tc            = tc_q;
    assign bus.cvt_valid_out = cvt_valid_q;
    assign bus.cvt_data_out  = cvt_data_q;
endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH 4 (main), plus 2, 8 and 32 for the
// parameter sweep; expected values are hand-computed tables or a small model.
module tb_gray_counter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    gray_counter_if #(.WIDTH(4))  i4();
    gray_counter_if #(.WIDTH(2))  i2();
    gray_counter_if #(.WIDTH(8))  i8();
    gray_counter_if #(.WIDTH(32)) i32();

    gray_counter #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
    gray_counter #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2));
    gray_counter #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    gray_counter #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  prev_gray;
        logic [31:0] v;
        logic [31:0] g;
        n_chk  = 0;
        n_fail = 0;

        rst_n = 1'b0;
        i4.en = 1'b1; i4.up = 1'b1; i4.load = 1'b1; i4.load_bin = 4'h5;
        i4.cvt_valid_in = 1'b1; i4.cvt_mode = 1'b0; i4.cvt_data_in = 4'hB;
        i2.en = 1'b0; i2.up = 1'b1; i2.load = 1'b0; i2.load_bin = '0;
        i2.cvt_valid_in = 1'b0; i2.cvt_mode = 1'b0; i2.cvt_data_in = '0;
        i8.en = 1'b0; i8.up = 1'b1; i8.load = 1'b0; i8.load_bin = '0;
        i8.cvt_valid_in = 1'b0; i8.cvt_mode = 1'b0; i8.cvt_data_in = '0;
        i32.en = 1'b0; i32.up = 1'b1; i32.load = 1'b0; i32.load_bin = '0;
        i32.cvt_valid_in = 1'b0; i32.cvt_mode = 1'b0; i32.cvt_data_in = '0;

        // Reset wins over load/en/valid
        step();
        step();
        chk("rst_bin", 32'(i4.bin), 32'h0);
        chk("rst_gray", 32'(i4.gray), 32'h0);
        chk("rst_tc", 32'(i4.tc), 32'h0);
        chk("rst_cvt_valid", 32'(i4.cvt_valid_out), 32'h0);
        chk("rst_cvt_data", 32'(i4.cvt_data_out), 32'h0);

        rst_n = 1'b1; i4.load = 1'b0; i4.cvt_valid_in = 1'b0;
        prev_gray = 4'h0;
        // Up-count 17 steps: full cycle and wrap back to 0000 then 0001
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("up_bin_%0d", k), 32'(i4.bin), 32'(k % 16));
            chk($sformatf("up_gray_%0d", k), 32'(i4.gray), 32'(gtab[k % 16]));
            chk($sformatf("up_tc_%0d", k), 32'(i4.tc), 32'(k == 16));
            chk($sformatf("up_onebit_%0d", k), 32'($countones(prev_gray ^ i4.gray)), 32'd1);
            chk($sformatf("up_consist_%0d", k), 32'(i4.gray), 32'(i4.bin ^ (i4.bin >> 1)));
            prev_gray = i4.gray;
        end

        // Down through 0 to all-ones
        i4.up = 1'b0;
        step();
        chk("dn_bin0", 32'(i4.bin), 32'h0);
        chk("dn_tc0", 32'(i4.tc), 32'h0);
        step();
        chk("dn_wrap_bin", 32'(i4.bin), 32'hF);
        chk("dn_wrap_gray", 32'(i4.gray), 32'h8);
        chk("dn_wrap_tc", 32'(i4.tc), 32'h1);
        step();
        chk("dn_next_bin", 32'(i4.bin), 32'hE);
        chk("dn_next_gray", 32'(i4.gray), 32'h9);
        chk("dn_next_tc", 32'(i4.tc), 32'h0);

        i4.en = 1'b0;
        step();
        chk("hold_bin", 32'(i4.bin), 32'hE);
        chk("hold_gray", 32'(i4.gray), 32'h9);

        // Load overrides enable
        i4.load = 1'b1; i4.en = 1'b1; i4.up = 1'b1; i4.load_bin = 4'h5;
        step();
        chk("load_bin", 32'(i4.bin), 32'h5);
        chk("load_gray", 32'(i4.gray), 32'h7);
        chk("load_tc", 32'(i4.tc), 32'h0);
        i4.load = 1'b0; i4.up = 1'b0;
        step();
        chk("after_load_bin", 32'(i4.bin), 32'h4);
        chk("after_load_gray", 32'(i4.gray), 32'h6);

        // Load of all-ones then no tc on load itself
        i4.load = 1'b1; i4.load_bin = 4'hF; i4.up = 1'b1;
        step();
        chk("load_f_tc", 32'(i4.tc), 32'h0);
        i4.load = 1'b0;
        step();
        chk("load_f_wrap_bin", 32'(i4.bin), 32'h0);
        chk("load_f_wrap_tc", 32'(i4.tc), 32'h1);

        // Converter stream, counter idle
        i4.en = 1'b0;
        i4.cvt_valid_in = 1'b1; i4.cvt_mode = 1'b0; i4.cvt_data_in = 4'hB;
        step();
        chk("cvt1_valid", 32'(i4.cvt_valid_out), 32'h1);
        chk("cvt1_data", 32'(i4.cvt_data_out), 32'hE);
        i4.cvt_mode = 1'b1; i4.cvt_data_in = 4'hE;
        step();
        chk("cvt2_valid", 32'(i4.cvt_valid_out), 32'h1);
        chk("cvt2_data", 32'(i4.cvt_data_out), 32'hB);
        i4.cvt_mode = 1'b1; i4.cvt_data_in = 4'h8;
        step();
        chk("cvt3_valid", 32'(i4.cvt_valid_out), 32'h1);
        chk("cvt3_data", 32'(i4.cvt_data_out), 32'hF);
        i4.cvt_valid_in = 1'b0; i4.cvt_mode = 1'b0; i4.cvt_data_in = 4'h5;
        step();
        chk("cvt_idle_valid", 32'(i4.cvt_valid_out), 32'h0);
        chk("cvt_idle_hold", 32'(i4.cvt_data_out), 32'hF);

        // Counter and converter together
        i4.en = 1'b1; i4.up = 1'b1;
        i4.cvt_valid_in = 1'b1; i4.cvt_mode = 1'b0; i4.cvt_data_in = 4'h6;
        step();
        chk("both_bin", 32'(i4.bin), 32'h1);
        chk("both_gray", 32'(i4.gray), 32'h1);
        chk("both_cvt", 32'(i4.cvt_data_out), 32'h5);

        // Mid-activity reset
        rst_n = 1'b0;
        step();
        chk("midrst_bin", 32'(i4.bin), 32'h0);
        chk("midrst_gray", 32'(i4.gray), 32'h0);
        chk("midrst_cvt_valid", 32'(i4.cvt_valid_out), 32'h0);
        chk("midrst_cvt_data", 32'(i4.cvt_data_out), 32'h0);
        rst_n = 1'b1; i4.en = 1'b0; i4.cvt_valid_in = 1'b0;

        // WIDTH 2 wrap: tc every 4th enabled cycle
        i2.en = 1'b1; i2.up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("w2_bin_%0d", k), 32'(i2.bin), 32'(k % 4));
            chk($sformatf("w2_tc_%0d", k), 32'(i2.tc), 32'((k % 4) == 0));
        end
        i2.en = 1'b0;

        // WIDTH 2 and 8 exhaustive encode->decode round trip
        for (int k = 0; k < 4; k++) begin
            v = 32'(k);
            i2.cvt_valid_in = 1'b1; i2.cvt_mode = 1'b0; i2.cvt_data_in = 2'(v);
            step();
            chk($sformatf("w2_enc_%0d", k), 32'(i2.cvt_data_out), v ^ (v >> 1));
            g = 32'(i2.cvt_data_out);
            i2.cvt_mode = 1'b1; i2.cvt_data_in = 2'(g);
            step();
            chk($sformatf("w2_rt_%0d", k), 32'(i2.cvt_data_out), v);
        end
        i2.cvt_valid_in = 1'b0;

        for (int k = 0; k < 256; k++) begin
            v = 32'(k);
            i8.cvt_valid_in = 1'b1; i8.cvt_mode = 1'b0; i8.cvt_data_in = 8'(v);
            step();
            chk($sformatf("w8_enc_%0d", k), 32'(i8.cvt_data_out), v ^ (v >> 1));
            g = 32'(i8.cvt_data_out);
            i8.cvt_mode = 1'b1; i8.cvt_data_in = 8'(g);
            step();
            chk($sformatf("w8_rt_%0d", k), 32'(i8.cvt_data_out), v);
        end
        i8.cvt_valid_in = 1'b0;

        // WIDTH 32 random round trip, plus all-ones edge
        for (int k = 0; k < 24; k++) begin
            v = (k == 0) ? 32'hFFFF_FFFF : $urandom;
            i32.cvt_valid_in = 1'b1; i32.cvt_mode = 1'b0; i32.cvt_data_in = v;
            step();
            chk($sformatf("w32_enc_%0d", k), i32.cvt_data_out, v ^ (v >> 1));
            g = i32.cvt_data_out;
            i32.cvt_mode = 1'b1; i32.cvt_data_in = g;
            step();
            chk($sformatf("w32_rt_%0d", k), i32.cvt_data_out, v);
        end
        i32.cvt_valid_in = 1'b0;

        // WIDTH 32 down-wrap from 0
        i32.en = 1'b1; i32.up = 1'b0;
        step();
        chk("w32_dn_bin", i32.bin, 32'hFFFF_FFFF);
        chk("w32_dn_gray", i32.gray, 32'h8000_0000);
        chk("w32_dn_tc", 32'(i32.tc), 32'h1);
        i32.en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised Gray-code counter with an independent registered code converter; the sequential successor to the team's fixed 4-bit combinational binary-to-Gray encoder. The counter produces a Gray sequence (one bit changes per step) with up/down, enable and parallel load, plus its binary equivalent and a wrap flag. It suits clock-domain-crossing pointers and position encoders. The converter channel gives a 1-cycle pipelined binary↔Gray translation so downstream logic need not carry its own combinational converters.

## Interface
Parameters:
- WIDTH, 4, counter and converter data width; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement (binary sense).
- load  input  1  parallel load strobe; overrides en.
- load_bin  input  WIDTH  binary value to load.
- bin  output  WIDTH  current count, binary, registered.
- gray  output  WIDTH  current count, Gray-encoded, registered.
- tc  output  1  wrap flag, registered, 1-cycle pulse.
- cvt_valid_in  input  1  converter input valid.
- cvt_mode  input  1  0 = binary→Gray, 1 = Gray→binary.
- cvt_data_in  input  WIDTH  converter operand.
- cvt_valid_out  output  1  converter result valid.
- cvt_data_out  output  WIDTH  converter result.

## Operation
- Single clock, synchronous active-low reset; no asynchronous paths, no handshake back-pressure.
- Counter state held in binary; gray is registered from the next binary value, so bin and gray always update in the same edge and are mutually consistent: gray = bin ^ (bin >> 1).
- Per cycle, priority: rst_n low > load > en > hold.
  - load: bin ← load_bin, gray ← encode(load_bin), tc ← 0.
  - en & up: bin ← bin + 1 modulo 2^WIDTH.
  - en & !up: bin ← bin − 1 modulo 2^WIDTH.
  - otherwise: bin, gray hold; tc ← 0.
- Wrap: tc ← 1 on a step from all-ones to 0 (up) or from 0 to all-ones (down); else 0. tc is high in the same cycle the wrapped value appears on bin/gray.
- Direction may change any cycle; the step taken uses the up value sampled at that edge.
- Consecutive gray values differ in exactly one bit on every en step, including wrap in both directions. Loads are exempt.
- Converter, independent of counter:
  - Encode (mode 0): out = d ^ (d >> 1).
  - Decode (mode 1): out[WIDTH−1] = d[WIDTH−1]; out[i] = out[i+1] ^ d[i], i descending.
  - cvt_valid_out ← cvt_valid_in every cycle; cvt_data_out updates only when cvt_valid_in = 1, otherwise holds its last value.
  - Back-to-back valid inputs give back-to-back results; no bubbles.

## Timing
- Reset values (the edge after rst_n sampled low): bin = 0, gray = 0, tc = 0, cvt_valid_out = 0, cvt_data_out = 0.
- rst_n low mid-count or with load/en/cvt_valid_in high: reset wins; all outputs take reset values at that edge.
- Counter latency: 1 cycle from en/load sampled to new bin/gray/tc.
- Converter latency: 1 cycle; result for the operand sampled at edge N is visible after edge N.
- Simultaneous load and en: load wins, no step, tc = 0.
- Simultaneous counter and converter activity: fully independent; no interaction.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold rst_n = 0 with en = 1, load = 1, cvt_valid_in = 1 for 2 cycles → bin = 0, gray = 0, tc = 0, cvt_valid_out = 0, cvt_data_out = 0; release → count starts the next cycle.
- WIDTH = 4 up-count, en = 1 for 17 cycles from 0 → gray sequence 0000, 0001, 0011, 0010, 0110, … 1000, 0000; exactly one bit change per step; tc = 1 only when the value returns to 0000; gray == bin ^ (bin >> 1) every cycle.
- Down-count from 0 → bin = 1111, gray = 1000, tc = 1 for that cycle; next step bin = 1110, gray = 1001, tc = 0.
- Load priority: load = 1, en = 1, load_bin = 0101 → bin = 0101, gray = 0111, tc = 0; then en, up = 0 → bin = 0100, gray = 0110.
- Converter streaming, WIDTH = 4: valid on 3 consecutive cycles: mode 0 data 1011, mode 1 data 1110, mode 1 data 1000 → cvt_data_out 1110, 1011, 1111 on consecutive cycles, cvt_valid_out high for 3 cycles; then cvt_valid_in = 0 → output holds 1111, valid drops.
- Parameter sweep: WIDTH = 2, 8, 32. Exhaustive (or random for 32) encode→decode round trip returns the input. Full up-wrap at WIDTH = 2 → tc every 4th enabled cycle.
